// File: rtl/sumador_seq.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over N = WIDTH/CHUNK cycles.
// The result, carry-out and signed overflow stay valid from the done pulse until the next accepted start.
module sumador_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N   = WIDTH / CHUNK;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_next;
    logic [KW-1:0]    k_reg;
    logic             carry_reg, cout_reg, ovf_reg;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             accept, last_chunk;

    // Operand chunk selection as a one-hot AND-OR mux over the chunk counter.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (k_reg == KW'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    assign accept     = start && (state_reg != RUN);
    assign last_chunk = (k_reg == K_LAST);

    // Only the slice addressed by k takes the new chunk sum; the others keep their value.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign s_next[gi*CHUNK +: CHUNK] = (k_reg == KW'(gi)) ? chunk_sum[CHUNK-1:0]
                                                                 : s_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            k_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                a_reg     <= a;
                b_reg     <= sub ? ~b : b;
                carry_reg <= sub;
                k_reg     <= '0;
                s_reg     <= '0;
            end else if (state_reg == RUN) begin
                s_reg     <= s_next;
                carry_reg <= chunk_sum[CHUNK];
                if (last_chunk) begin
                    k_reg    <= '0;
                    cout_reg <= chunk_sum[CHUNK];
                    ovf_reg  <= (a_reg[MSB] == b_reg[MSB]) && (s_next[MSB] != a_reg[MSB]);
                end else begin
                    k_reg <= k_reg + KW'(1);
                end
            end
        end
    end

    assign s    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_sumador_seq.sv
// Directed and randomized checks of sumador_seq (CHUNK=8 and CHUNK=32) against an
// arithmetic reference model.
module tb_sumador_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [31:0] s;

    logic        start32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] s32;

    int n_cmp = 0;
    int n_bad = 0;

    sumador_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
    );

    sumador_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the full operands.
    task automatic model(input logic m_sub, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] es, output logic ec, output logic eo);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = m_sub ? sx - sy : sx + sy;
        es = m_sub ? x - y : x + y;
        ec = m_sub ? (x >= y) : (({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF);
        eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic run_op(input string tag, input logic o_sub, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] es, input logic ec,
                          input logic eo);
        start = 1'b1; sub = o_sub; a = x; b = y;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            a = $urandom; b = $urandom; sub = 1'($urandom);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_s"}, s, es);
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        $display("op %s sub=%0d a=%h b=%h -> s=%h cout=%0d ovf=%0d", tag, o_sub, x, y, s, cout, ovf);
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, s, es);
    endtask

    initial begin
        logic [31:0] es, ra, rb;
        logic        ec, eo, rs;
        int          ndone;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", s, 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // First edge after reset release accepts the start
        reset = 1'b0;
        run_op("add_wrap", 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_neg", 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Reset during the second RUN cycle aborts the operation
        start = 1'b1; sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", s, 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_nopulse", 32'(ndone), 32'd0);
        $display("op abort: done pulses after reset=%0d", ndone);

        // Start re-pulsed mid-run is ignored
        start = 1'b1; sub = 1'b0; a = 32'h0F0F_0F0F; b = 32'h0101_0101;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; sub = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ign_done", 32'(done), 32'd1);
        check("ign_s", s, 32'h1010_1010);
        ndone = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) ndone++;
        end
        check("ign_once", 32'(ndone), 32'd1);
        $display("op ignore: s=%h done pulses=%0d", s, ndone);

        // Back-to-back operations with start held high
        start = 1'b1;
        for (int j = 0; j < 6; j++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            a = ra; b = rb; sub = rs;
            model(rs, ra, rb, es, ec, eo);
            tick();
            for (int c = 0; c < 4; c++) begin
                check("b2b_nodone", 32'(done), 32'd0);
                a = $urandom; b = $urandom; sub = 1'($urandom);
                tick();
            end
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_s", s, es);
            check("b2b_cout", 32'(cout), 32'(ec));
            check("b2b_ovf", 32'(ovf), 32'(eo));
            $display("op b2b%0d sub=%0d a=%h b=%h -> s=%h cout=%0d ovf=%0d", j, rs, ra, rb, s, cout, ovf);
        end
        start = 1'b0;
        tick();
        tick();

        // Random single operations
        for (int j = 0; j < 12; j++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (j == 0) rb = ra;
            model(rs, ra, rb, es, ec, eo);
            run_op("rand", rs, ra, rb, es, ec, eo);
        end

        // Single-chunk configuration: done one cycle after start
        start32 = 1'b1; sub32 = 1'b0; a32 = 32'h0000_0001; b32 = 32'hFFFF_FFFF;
        tick();
        start32 = 1'b0;
        check("c32_busy", 32'(busy32), 32'd1);
        check("c32_nodone", 32'(done32), 32'd0);
        tick();
        check("c32_done", 32'(done32), 32'd1);
        check("c32_s", s32, 32'h0000_0000);
        check("c32_cout", 32'(cout32), 32'd1);
        check("c32_ovf", 32'(ovf32), 32'd0);
        $display("op c32 a=00000001 b=ffffffff -> s=%h cout=%0d ovf=%0d", s32, cout32, ovf32);
        tick();
        check("c32_pulse", 32'(done32), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sumador_seq.md
SUMADOR_SEQ -- requirements
Module: sumador_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only when not busy.
REQ-006 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  first operand; sampled with start.
REQ-008 b  input  WIDTH  second operand; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse when s, cout and ovf become valid.
REQ-011 s  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL do all of the following at the edge: latch a into A_r; latch b (or ~b when sub=1) into B_r; set carry to sub; clear chunk counter k; clear s; enter RUN.
REQ-016 In RUN, each cycle SHALL add chunk k of A_r, chunk k of B_r and carry (CHUNK+1 bits); bits write to s[k*CHUNK +: CHUNK]; carry updates from the sum MSB; k increments.
REQ-017 When chunk N-1 is processed, the FSM SHALL enter DONE; cout = final carry; ovf = (A_r[MSB] == B_r[MSB]) && (s[MSB] != A_r[MSB]).
REQ-018 Latency: start sampled at edge t -> done=1 during the cycle after edge t+N; busy=1 during the cycles after edges t..t+N-1.
REQ-019 done SHALL be high only in DONE; DONE lasts exactly one cycle, then goes to IDLE, or to RUN if start=1.
REQ-020 busy SHALL be high only in RUN.
REQ-021 start while in RUN SHALL be ignored; operands and mode SHALL NOT change mid-operation.
REQ-022 s, cout and ovf SHALL hold the last result in IDLE and DONE until the next accepted start.
REQ-023 s is undefined-but-stable during RUN; consumers SHALL use it only when done=1 or afterwards.
REQ-024 CHUNK = WIDTH (N=1) SHALL be legal: done follows start by one cycle.
REQ-025 The chunk counter SHALL be ceil(log2(N)) bits wide (minimum 1) and SHALL never wrap during RUN.

Reset
REQ-026 reset=1 at any edge SHALL force IDLE, with busy=0, done=0, s=0, cout=0, ovf=0, k=0, carry=0, A_r=0 and B_r=0.
REQ-027 reset SHALL take priority over start and abort any operation in RUN without a done pulse.
REQ-028 The first start SHALL be accepted on the first edge after reset deasserts.

Verification (WIDTH=32, CHUNK=8 unless noted)
REQ-029 Start, sub=0, a=0x00000001, b=0xFFFFFFFF -> busy 4 cycles, then done pulse with s=0x00000000, cout=1, ovf=0.
REQ-030 Start, sub=0, a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, cout=0, ovf=1.
REQ-031 Two subtractions:
- sub=1, a=5, b=7 -> s=0xFFFFFFFE, cout=0, ovf=0.
- sub=1, a=0x80000000, b=1 -> s=0x7FFFFFFF, cout=1, ovf=1.
REQ-032 Start accepted, start re-pulsed with new operands two cycles later -> second start ignored; result is from the first operands; done exactly once.
REQ-033 Reset asserted during cycle 2 of RUN -> next cycle busy=0, done=0, s=0, and no done pulse follows.
REQ-034 Start held high through DONE -> back-to-back operations, with done every N+1 cycles; also rerun REQ-029 with CHUNK=32 -> done one cycle after start.
